// File: rtl/pueo_trig_admit.sv
// Trigger admission scheduler: RF/SW arbitration, holdoff spacing, buffer credits, run sequencing.
// Optional PUEO_TRIG_ADMIT_STATS_EN adds a saturating dropped-request counter (dropped_o).
module pueo_trig_admit #(
  parameter int unsigned NBUF     = 4,
  parameter int unsigned TIMEBITS = 16,
  parameter int unsigned HOLDBITS = 16
) (
  input  logic                aclk_i,
  input  logic                aresetn_i,
  input  logic                run_rst_i,
  input  logic                run_stop_i,
  input  logic [HOLDBITS-1:0] holdoff_i,
  input  logic                rf_trig_i,
  input  logic [TIMEBITS-1:0] rf_time_i,
  input  logic                sw_trig_i,
  input  logic [TIMEBITS-1:0] sw_time_i,
  input  logic                evdone_i,
  output logic [TIMEBITS-1:0] trig_time_o,
  output logic                trig_time_valid_o,
  output logic                trig_src_o,
  output logic [15:0]         trig_num_o,
  output logic [3:0]          free_o,
  output logic                running_o,
  output logic                busy_o
`ifdef PUEO_TRIG_ADMIT_STATS_EN
  ,
  output logic [15:0]         dropped_o
`endif
);

  localparam int unsigned NUMBITS  = 16;
  localparam int unsigned FREEBITS = 4;
  localparam logic [FREEBITS-1:0] FULL = FREEBITS'(NBUF);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t              state, state_nx;
  logic [HOLDBITS-1:0] hold_cap, hold_cap_nx;
  logic [HOLDBITS-1:0] holdcnt, holdcnt_nx;
  logic [NUMBITS-1:0]  trig_num, trig_num_nx;
  logic [FREEBITS-1:0] free_nx;
  logic [TIMEBITS-1:0] trig_time_nx;
  logic                trig_src_nx;
  logic [NUMBITS-1:0]  trig_num_o_nx;
  logic                accept_c;
  logic                run_clear_c;

  // State register plus all registered datapath and outputs
  always_ff @(posedge aclk_i) begin
    if (!aresetn_i) begin
      state             <= ST_IDLE;
      hold_cap          <= '0;
      holdcnt           <= '0;
      trig_num          <= '0;
      free_o            <= FULL;
      trig_time_o       <= '0;
      trig_time_valid_o <= 1'b0;
      trig_src_o        <= 1'b0;
      trig_num_o        <= '0;
      running_o         <= 1'b0;
      busy_o            <= 1'b0;
    end else begin
      state             <= state_nx;
      hold_cap          <= hold_cap_nx;
      holdcnt           <= holdcnt_nx;
      trig_num          <= trig_num_nx;
      free_o            <= free_nx;
      trig_time_o       <= trig_time_nx;
      trig_time_valid_o <= accept_c;
      trig_src_o        <= trig_src_nx;
      trig_num_o        <= trig_num_o_nx;
      running_o         <= (state_nx == ST_RUN);
      busy_o            <= (free_nx < FULL);
    end
  end

  // Next-state, admission decision and datapath updates
  always_comb begin
    state_nx      = state;
    hold_cap_nx   = hold_cap;
    holdcnt_nx    = (holdcnt != '0) ? holdcnt - HOLDBITS'(1) : '0;
    trig_num_nx   = trig_num;
    trig_time_nx  = trig_time_o;
    trig_src_nx   = trig_src_o;
    trig_num_o_nx = trig_num_o;
    accept_c      = 1'b0;
    run_clear_c   = 1'b0;

    unique case (state)
      ST_IDLE: begin
        if (run_rst_i) begin
          state_nx    = ST_RUN;
          run_clear_c = 1'b1;
        end
      end
      ST_RUN: begin
        accept_c = (rf_trig_i | sw_trig_i) & (free_o != '0) & (holdcnt == '0)
                 & ~run_stop_i & ~run_rst_i;
        if (run_rst_i) begin
          run_clear_c = 1'b1;
        end else if (run_stop_i) begin
          state_nx = (free_o < FULL) ? ST_DRAIN : ST_IDLE;
        end
      end
      ST_DRAIN: begin
        if (free_o == FULL) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase

    if (run_clear_c) begin
      hold_cap_nx = holdoff_i;
      holdcnt_nx  = '0;
      trig_num_nx = '0;
    end

    // RF has fixed priority; the losing request is simply discarded
    if (accept_c) begin
      holdcnt_nx    = hold_cap;
      trig_num_nx   = trig_num + NUMBITS'(1);
      trig_num_o_nx = trig_num;
      trig_src_nx   = ~rf_trig_i;
      trig_time_nx  = rf_trig_i ? rf_time_i : sw_time_i;
    end

    free_nx = free_o;
    unique case ({accept_c, evdone_i})
      2'b10:   free_nx = free_o - FREEBITS'(1);
      2'b01:   free_nx = (free_o == FULL) ? free_o : free_o + FREEBITS'(1);
      default: free_nx = free_o;
    endcase
  end

`ifdef PUEO_TRIG_ADMIT_STATS_EN
  logic [1:0]  drop_inc_c;
  logic [16:0] drop_sum_c;

  always_comb begin
    drop_inc_c = '0;
    if (state == ST_RUN)
      drop_inc_c = 2'(rf_trig_i) + 2'(sw_trig_i) - 2'(accept_c);
    drop_sum_c = 17'(dropped_o) + 17'(drop_inc_c);
  end

  // Saturating count of requests discarded while running
  always_ff @(posedge aclk_i) begin
    if (!aresetn_i || run_clear_c) dropped_o <= '0;
    else if (drop_sum_c[16])       dropped_o <= 16'hFFFF;
    else                           dropped_o <= drop_sum_c[15:0];
  end
`endif

endmodule

// File: tb/tb_pueo_trig_admit.sv
// Directed self-checking bench for pueo_trig_admit (NBUF=4).
module tb_pueo_trig_admit;

  logic        aclk_i = 1'b0;
  logic        aresetn_i, run_rst_i, run_stop_i, rf_trig_i, sw_trig_i, evdone_i;
  logic [15:0] holdoff_i, rf_time_i, sw_time_i;
  logic [15:0] trig_time_o, trig_num_o;
  logic        trig_time_valid_o, trig_src_o, running_o, busy_o;
  logic [3:0]  free_o;
`ifdef PUEO_TRIG_ADMIT_STATS_EN
  logic [15:0] dropped_o;
`endif

  int errors = 0;
  int checks = 0;

  pueo_trig_admit #(.NBUF(4), .TIMEBITS(16), .HOLDBITS(16)) dut (
    .aclk_i(aclk_i), .aresetn_i(aresetn_i), .run_rst_i(run_rst_i),
    .run_stop_i(run_stop_i), .holdoff_i(holdoff_i), .rf_trig_i(rf_trig_i),
    .rf_time_i(rf_time_i), .sw_trig_i(sw_trig_i), .sw_time_i(sw_time_i),
    .evdone_i(evdone_i), .trig_time_o(trig_time_o),
    .trig_time_valid_o(trig_time_valid_o), .trig_src_o(trig_src_o),
    .trig_num_o(trig_num_o), .free_o(free_o), .running_o(running_o),
    .busy_o(busy_o)
`ifdef PUEO_TRIG_ADMIT_STATS_EN
    , .dropped_o(dropped_o)
`endif
  );

  always #5 aclk_i = ~aclk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk_i);
    #1;
  endtask

  task automatic idle_inputs();
    run_rst_i = 0; run_stop_i = 0; rf_trig_i = 0; sw_trig_i = 0; evdone_i = 0;
  endtask

  task automatic start_run(input logic [15:0] hold);
    holdoff_i = hold; run_rst_i = 1;
    tick();
    run_rst_i = 0;
  endtask

  initial begin
    idle_inputs();
    holdoff_i = 0; rf_time_i = 0; sw_time_i = 0;
    aresetn_i = 0;
    tick(); tick();
    check("rst_valid", 32'(trig_time_valid_o), 0);
    check("rst_free", 32'(free_o), 4);
    check("rst_running", 32'(running_o), 0);
    check("rst_busy", 32'(busy_o), 0);
    check("rst_num", 32'(trig_num_o), 0);
    aresetn_i = 1;

    // First trigger
    start_run(16'd0);
    check("run_running", 32'(running_o), 1);
    rf_trig_i = 1; rf_time_i = 16'h1234;
    tick();
    rf_trig_i = 0;
    check("t1_valid", 32'(trig_time_valid_o), 1);
    check("t1_time", 32'(trig_time_o), 32'h1234);
    check("t1_src", 32'(trig_src_o), 0);
    check("t1_num", 32'(trig_num_o), 0);
    check("t1_free", 32'(free_o), 3);
    check("t1_busy", 32'(busy_o), 1);
    tick();
    check("t1_vlow", 32'(trig_time_valid_o), 0);
    check("t1_hold", 32'(trig_time_o), 32'h1234);

    // Credit exhaustion
    evdone_i = 1; tick(); evdone_i = 0;
    check("ret_free", 32'(free_o), 4);
    start_run(16'd0);
    for (int i = 0; i < 5; i++) begin
      rf_trig_i = 1; rf_time_i = 16'(16'h0100 + i);
      tick();
      check($sformatf("cr_valid%0d", i), 32'(trig_time_valid_o), (i < 4) ? 1 : 0);
      if (i < 4) check($sformatf("cr_num%0d", i), 32'(trig_num_o), 32'(i));
    end
    rf_trig_i = 0;
    check("cr_free", 32'(free_o), 0);
`ifdef PUEO_TRIG_ADMIT_STATS_EN
    check("cr_dropped", 32'(dropped_o), 1);
`endif

    // Holdoff spacing of 3
    for (int i = 0; i < 4; i++) begin evdone_i = 1; tick(); end
    evdone_i = 0;
    check("ho_free0", 32'(free_o), 4);
    start_run(16'd3);
    for (int k = 0; k < 10; k++) begin
      rf_trig_i = 1; rf_time_i = 16'(k);
      tick();
      check($sformatf("ho_valid%0d", k), 32'(trig_time_valid_o),
            (k == 0 || k == 4 || k == 8) ? 1 : 0);
      if (k == 8) check("ho_num8", 32'(trig_num_o), 2);
    end
    rf_trig_i = 0;
    check("ho_free", 32'(free_o), 1);
    for (int i = 0; i < 3; i++) begin evdone_i = 1; tick(); end
    evdone_i = 0;

    // Arbitration and simultaneous credit return
    start_run(16'd0);
    rf_trig_i = 1; rf_time_i = 16'hAAAA; sw_trig_i = 1; sw_time_i = 16'h5555;
    tick();
    rf_trig_i = 0;
    check("arb_time", 32'(trig_time_o), 32'hAAAA);
    check("arb_src", 32'(trig_src_o), 0);
    check("arb_free", 32'(free_o), 3);
    evdone_i = 1;
    tick();
    sw_trig_i = 0; evdone_i = 0;
    check("sw_valid", 32'(trig_time_valid_o), 1);
    check("sw_src", 32'(trig_src_o), 1);
    check("sw_time", 32'(trig_time_o), 32'h5555);
    check("sw_free", 32'(free_o), 3);
`ifdef PUEO_TRIG_ADMIT_STATS_EN
    check("arb_dropped", 32'(dropped_o), 1);
`endif

    // Stop with two outstanding -> drain
    rf_trig_i = 1; tick(); rf_trig_i = 0;
    check("dr_free2", 32'(free_o), 2);
    run_stop_i = 1; tick(); run_stop_i = 0;
    check("dr_running", 32'(running_o), 0);
    rf_trig_i = 1; tick(); rf_trig_i = 0;
    check("dr_ignored", 32'(trig_time_valid_o), 0);
    run_rst_i = 1; tick(); run_rst_i = 0;
    check("dr_rst_ign", 32'(running_o), 0);
    evdone_i = 1; tick(); tick(); evdone_i = 0;
    check("dr_free4", 32'(free_o), 4);
    check("dr_busy", 32'(busy_o), 0);
    tick();
    rf_trig_i = 1; tick(); rf_trig_i = 0;
    check("idle_ignored", 32'(trig_time_valid_o), 0);
    check("idle_running", 32'(running_o), 0);

    // trig_num wrap
    start_run(16'd0);
    check("wr_running", 32'(running_o), 1);
    rf_trig_i = 1; evdone_i = 1;
    for (int i = 0; i < 65535; i++) tick();
    check("wr_pre", 32'(trig_num_o), 32'hFFFE);
    tick();
    check("wr_ffff", 32'(trig_num_o), 32'hFFFF);
    tick();
    check("wr_zero", 32'(trig_num_o), 0);
    check("wr_valid", 32'(trig_time_valid_o), 1);
    check("wr_free", 32'(free_o), 4);
    rf_trig_i = 0;
    tick();
    check("ovf_free", 32'(free_o), 4);
    evdone_i = 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
